lut_neuron_loader: RTL and testbench

- Runtime-writable LUT neuron: the write/configuration end for the fixed truth-table neurons in the logicnets layers.
- A serial valid/ready configuration stream fills a 2^IN_W x OUT_W table held in distributed RAM.
- Inference inputs then index the table, with a registered output.
- Sits beside each reconfigurable layer neuron; a layer-level config controller drives it.

---
 rtl/lut_neuron_pkg.sv | 24 ++
 rtl/lut_neuron_ram.sv | 40 ++++
 rtl/lut_neuron_loader.sv | 176 +++++++++++++++++
 tb/tb_lut_neuron_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared types and sizing helpers for the runtime-writable LUT neuron.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Number of CFG_W beats needed to fill a 2^in_w x out_w table.
  function automatic int calc_beats(input int in_w, input int out_w, input int cfg_w);
    return ((1 << in_w) * out_w) / cfg_w;
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Entry a sits at flat bits a*out_w .. a*out_w+out_w-1; beat k bit j is flat bit k*cfg_w+j.
  function automatic int entry_lsb(input int addr, input int out_w);
    return addr * out_w;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// Truth-table storage: word-written by config beats, bit-read by inference.
// LUT_NEURON_READBACK_EN adds a word-wide readback port.
module lut_neuron_ram
  import lut_neuron_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int OUT_W = 1,
  parameter int CFG_W = 8,
  localparam int BEATS = calc_beats(IN_W, OUT_W, CFG_W),
  localparam int CNT_W = cnt_width(BEATS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  logic [CFG_W-1:0] wdata,
  input  logic [IN_W-1:0]  raddr,
  output logic [OUT_W-1:0] rdata
`ifdef LUT_NEURON_READBACK_EN
  ,
  input  logic [CNT_W-1:0] rb_addr,
  output logic [CFG_W-1:0] rb_rdata
`endif
);

  logic [BEATS-1:0][CFG_W-1:0] mem_q;
  logic [BEATS*CFG_W-1:0]      flat;

  // No reset: contents are undefined until a full image is written.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign flat  = mem_q;
  assign rdata = flat[entry_lsb(int'(raddr), OUT_W) +: OUT_W];

`ifdef LUT_NEURON_READBACK_EN
  assign rb_rdata = mem_q[rb_addr];
`endif

endmodule

// File: rtl/lut_neuron_loader.sv
// Loader FSM + registered inference for a runtime-writable LUT neuron.
// Optional LUT_NEURON_READBACK_EN streams the loaded image back out.
module lut_neuron_loader
  import lut_neuron_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int OUT_W = 1,
  parameter int CFG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_done,
  output logic             loaded,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data
`ifdef LUT_NEURON_READBACK_EN
  ,
  input  logic             rb_start,
  output logic             rb_valid,
  input  logic             rb_ready,
  output logic [CFG_W-1:0] rb_data
`endif
);

  localparam int DEPTH = 1 << IN_W;
  localparam int BEATS = calc_beats(IN_W, OUT_W, CFG_W);
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  if (((DEPTH * OUT_W) % CFG_W) != 0) begin : g_bad_cfg_w
    $error("lut_neuron_loader: DEPTH*OUT_W must be a multiple of CFG_W");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             loaded_q, loaded_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_W-1:0] rd;
  logic             accept;

  // cfg_start wins over a same-cycle beat, so that beat is neither written nor counted.
  assign accept = cfg_valid & ready_q & ~cfg_start;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == LAST) begin
            state_d  = RUN;
            loaded_d = 1'b1;
            done_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (cfg_start) begin
          state_d  = LOAD;
          cnt_d    = '0;
          loaded_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        loaded_d = 1'b0;
      end
    endcase
    ready_d     = (state_d == LOAD);
    out_valid_d = in_valid & loaded_q;
    out_data_d  = out_valid_d ? rd : '0;
  end

`ifdef LUT_NEURON_READBACK_EN
  logic             rb_valid_q, rb_valid_d;
  logic [CNT_W-1:0] rb_cnt_q, rb_cnt_d;
  logic [CFG_W-1:0] rb_rdata;

  always_comb begin
    rb_valid_d = rb_valid_q;
    rb_cnt_d   = rb_cnt_q;
    if (cfg_start) begin
      rb_valid_d = 1'b0;
    end else if (rb_valid_q) begin
      if (rb_ready) begin
        if (rb_cnt_q == LAST) rb_valid_d = 1'b0;
        else                  rb_cnt_d   = rb_cnt_q + CNT_W'(1);
      end
    end else if (rb_start && loaded_q && state_q == RUN) begin
      rb_valid_d = 1'b1;
      rb_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_valid_q <= 1'b0;
      rb_cnt_q   <= '0;
    end else begin
      rb_valid_q <= rb_valid_d;
      rb_cnt_q   <= rb_cnt_d;
    end
  end

  // Table is only written in LOAD, so the word is stable while the sink stalls.
  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_valid_q ? rb_rdata : '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      loaded_q    <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  lut_neuron_ram #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .CFG_W(CFG_W)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .waddr   (cnt_q),
    .wdata   (cfg_data),
    .raddr   (in_data),
    .rdata   (rd)
`ifdef LUT_NEURON_READBACK_EN
    ,
    .rb_addr (rb_cnt_q),
    .rb_rdata(rb_rdata)
`endif
  );

  assign cfg_ready = ready_q;
  assign cfg_done  = done_q;
  assign loaded    = loaded_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Self-checking bench for lut_neuron_loader: vector table, corner sequences, random vs. flat-bit model.
module tb_lut_neuron_loader;

  localparam int IN_W  = 6;
  localparam int OUT_W = 1;
  localparam int CFG_W = 8;
  localparam int DEPTH = 1 << IN_W;
  localparam int FLAT  = DEPTH * OUT_W;
  localparam int BEATS = FLAT / CFG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start, cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready, cfg_done, loaded;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
`ifdef LUT_NEURON_READBACK_EN
  logic             rb_start, rb_valid, rb_ready;
  logic [CFG_W-1:0] rb_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [FLAT-1:0] mdl_tbl;
  bit              mdl_loaded;

  typedef struct {
    logic [IN_W-1:0]  a;
    logic [OUT_W-1:0] exp;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  lut_neuron_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .CFG_W(CFG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_data (cfg_data),
    .cfg_ready(cfg_ready),
    .cfg_done (cfg_done),
    .loaded   (loaded),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data)
`ifdef LUT_NEURON_READBACK_EN
    ,
    .rb_start (rb_start),
    .rb_valid (rb_valid),
    .rb_ready (rb_ready),
    .rb_data  (rb_data)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] mdl_entry(input int a);
    logic [FLAT-1:0] t;
    t = mdl_tbl >> (a * OUT_W);
    return t[OUT_W-1:0];
  endfunction

  // Drives a start pulse (optionally with a colliding beat) then BEATS beats.
  task automatic load_image(input logic [CFG_W-1:0] img [BEATS], input bit gaps,
                            input bit collide, input logic [CFG_W-1:0] cdata);
    cfg_start = 1'b1; cfg_valid = collide; cfg_data = cdata;
    step();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    mdl_loaded = 1'b0;
    chk("ready_after_start", cfg_ready, 1);
    chk("loaded_after_start", loaded, 0);
    for (int k = 0; k < BEATS; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          step();
          chk("done_during_gap", cfg_done, 0);
        end
      end
      cfg_valid = 1'b1; cfg_data = img[k];
      step();
      cfg_valid = 1'b0;
      if (k < BEATS - 1) begin
        chk("done_early", cfg_done, 0);
        chk("loaded_early", loaded, 0);
      end else begin
        chk("done_pulse", cfg_done, 1);
        chk("loaded_set", loaded, 1);
      end
    end
    for (int k = 0; k < BEATS; k++)
      for (int j = 0; j < CFG_W; j++)
        mdl_tbl[k*CFG_W + j] = img[k][j];
    mdl_loaded = 1'b1;
    step();
    chk("done_single", cfg_done, 0);
    chk("ready_in_run", cfg_ready, 0);
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a++) begin
      in_valid = 1'b1; in_data = IN_W'(a);
      step();
      chk("sweep_valid", out_valid, 1);
      chk("sweep_data", out_data, mdl_entry(a));
    end
    in_valid = 1'b0;
    step();
    chk("sweep_idle_valid", out_valid, 0);
    chk("sweep_idle_data", out_data, 0);
  endtask

  task automatic rand_infer(input int n);
    bit v;
    int a;
    for (int i = 0; i < n; i++) begin
      v = 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, DEPTH - 1));
      in_valid = v; in_data = IN_W'(a);
      step();
      chk("rand_valid", out_valid, v & mdl_loaded);
      chk("rand_data", out_data, (v & mdl_loaded) ? mdl_entry(a) : '0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [CFG_W-1:0] img [BEATS];
    rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_data = '0;
    in_valid = 0; in_data = '0; mdl_tbl = '0; mdl_loaded = 0;
`ifdef LUT_NEURON_READBACK_EN
    rb_start = 0; rb_ready = 0;
`endif
    step();
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    // Inference before any load is dropped.
    in_valid = 1'b1; in_data = 6'h3F;
    repeat (5) begin
      step();
      chk("unloaded_valid", out_valid, 0);
      chk("unloaded_data", out_data, 0);
      chk("unloaded_flag", loaded, 0);
    end
    in_valid = 1'b0;

`ifdef LUT_NEURON_READBACK_EN
    rb_start = 1'b1;
    step();
    rb_start = 1'b0;
    chk("rb_ignored_unloaded", rb_valid, 0);
`endif

    // Image with entries 0 and 63 set.
    img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    load_image(img, 1'b1, 1'b0, '0);
    vt[0] = '{6'd0,  1'b1};
    vt[1] = '{6'd63, 1'b1};
    vt[2] = '{6'd1,  1'b0};
    vt[3] = '{6'd7,  1'b0};
    vt[4] = '{6'd62, 1'b0};
    vt[5] = '{6'd56, 1'b0};
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = vt[i].a;
      step();
      chk("vec_valid", out_valid, 1);
      chk("vec_data", out_data, vt[i].exp);
    end
    in_valid = 1'b0;

    sweep();

    // Restart after 3 beats, with a beat colliding on the restart cycle.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0; mdl_loaded = 1'b0;
    chk("reload_clears_loaded", loaded, 0);
    for (int k = 0; k < 3; k++) begin
      cfg_valid = 1'b1; cfg_data = CFG_W'($urandom);
      in_valid = 1'b1; in_data = IN_W'(k);
      step();
      chk("partial_no_done", cfg_done, 0);
      chk("partial_infer_drop", out_valid, 0);
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
    foreach (img[k]) img[k] = CFG_W'($urandom);
    load_image(img, 1'b1, 1'b1, 8'hFF);
    sweep();

    // Asynchronous reset in the middle of a load.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0; mdl_loaded = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_valid = 1'b1; cfg_data = CFG_W'($urandom);
      step();
    end
    cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", cfg_ready, 0);
    chk("async_rst_loaded", loaded, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_data = 8'hFF;
      in_valid = 1'b1; in_data = IN_W'($urandom);
      step();
      chk("post_rst_ready", cfg_ready, 0);
      chk("post_rst_loaded", loaded, 0);
      chk("post_rst_infer", out_valid, 0);
      chk("post_rst_data", out_data, 0);
    end
    cfg_valid = 1'b0; in_valid = 1'b0;
    foreach (img[k]) img[k] = CFG_W'($urandom);
    load_image(img, 1'b0, 1'b0, '0);
    sweep();

    // Random images and random inference traffic, including a reload window.
    for (int it = 0; it < 3; it++) begin
      foreach (img[k]) img[k] = CFG_W'($urandom);
      load_image(img, 1'b1, 1'b0, '0);
      rand_infer(150);
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0; mdl_loaded = 1'b0;
      chk("rand_reload_loaded", loaded, 0);
      rand_infer(10);
    end
    foreach (img[k]) img[k] = CFG_W'($urandom);
    load_image(img, 1'b0, 1'b0, '0);

`ifdef LUT_NEURON_READBACK_EN
    begin
      logic [CFG_W-1:0] rbimg [BEATS];
      logic [CFG_W-1:0] held;
      bit stalled, tog;
      int got;
      rbimg = '{8'hA5, 8'hC3, 8'hE1, 8'h0F, 8'hF0, 8'h1E, 8'h3C, 8'h5A};
      load_image(rbimg, 1'b0, 1'b0, '0);
      rb_start = 1'b1;
      step();
      rb_start = 1'b0;
      got = 0; stalled = 0; tog = 0; held = '0;
      for (int cyc = 0; cyc < 100 && got < BEATS; cyc++) begin
        rb_ready = tog; tog = ~tog;
        in_valid = 1'b1; in_data = IN_W'(cyc);
        if (rb_valid) begin
          if (stalled) chk("rb_stable", rb_data, held);
          if (rb_ready) begin
            chk("rb_data", rb_data, rbimg[got]);
            got++;
            stalled = 0;
          end else begin
            stalled = 1;
            held = rb_data;
          end
        end
        step();
        chk("rb_infer_valid", out_valid, 1);
        chk("rb_infer_data", out_data, mdl_entry(cyc));
      end
      rb_ready = 1'b0; in_valid = 1'b0;
      chk("rb_count", got, BEATS);
      step();
      chk("rb_end_valid", rb_valid, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
